// File: rtl/vga_pkg.sv
// Shared timing defaults, derived-position helpers and lock FSM encoding for
// the VGA receive-side sync detector.
package vga_pkg;

  localparam int unsigned DEF_VISIBLE_WIDTH  = 640;
  localparam int unsigned DEF_HORIZ_FP       = 16;
  localparam int unsigned DEF_HSYNC_WIDTH    = 96;
  localparam int unsigned DEF_HORIZ_BP       = 48;
  localparam int unsigned DEF_VISIBLE_HEIGHT = 480;
  localparam int unsigned DEF_VERT_FP        = 10;
  localparam int unsigned DEF_VSYNC_WIDTH    = 5;
  localparam int unsigned DEF_VERT_BP        = 30;
  localparam int unsigned DEF_LOCK_FRAMES    = 2;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    TRACK  = 2'd2,
    LOCKED = 2'd3
  } sync_state_e;

  function automatic int unsigned timing_total(input int unsigned visible,
                                               input int unsigned fp,
                                               input int unsigned sync_w,
                                               input int unsigned bp);
    return visible + fp + sync_w + bp;
  endfunction

  function automatic int unsigned sync_start(input int unsigned visible,
                                             input int unsigned fp);
    return visible + fp;
  endfunction

endpackage

// File: rtl/vga_sync_detect_if.sv
// Video-side bundle of the sync detector: incoming active-low syncs and the
// recovered coordinates / lock status handed to capture logic.
interface vga_sync_detect_if;
  logic        vga_hsync;
  logic        vga_vsync;
  logic [15:0] pixel_col;
  logic [15:0] pixel_row;
  logic        data_valid;
  logic        frame_start;
  logic        locked;
  logic [15:0] h_period;
  logic [15:0] v_period;

  modport master (
    output vga_hsync, vga_vsync,
    input  pixel_col, pixel_row, data_valid, frame_start, locked, h_period, v_period
  );

  modport slave (
    input  vga_hsync, vga_vsync,
    output pixel_col, pixel_row, data_valid, frame_start, locked, h_period, v_period
  );
endinterface

// File: rtl/vga_sync_detect_fall.sv
// Two-flop synchronizer for an asynchronous active-low sync line plus a
// one-cycle strobe on its synchronized falling edge; idles high out of reset.
module sync_fall_detect (
  input  logic pixel_clk,
  input  logic rst,
  input  logic sync_n,
  output logic fall
);

  logic sync_p0, sync_p1, sync_p2;

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      sync_p2 <= 1'b1;
    end else begin
      // p0/p1: metastability chain; p2: previous synced sample for edge detect
      sync_p0 <= sync_n;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign fall = sync_p2 & ~sync_p1;

endmodule

// File: rtl/vga_sync_detect.sv
// Recovers the transmitter's pixel column/row from incoming hsync/vsync,
// measures line/frame lengths and tracks timing lock.
module vga_sync_detect
  import vga_pkg::*;
#(
  parameter int unsigned VISIBLE_WIDTH  = DEF_VISIBLE_WIDTH,
  parameter int unsigned HORIZ_FP       = DEF_HORIZ_FP,
  parameter int unsigned HSYNC_WIDTH    = DEF_HSYNC_WIDTH,
  parameter int unsigned HORIZ_BP       = DEF_HORIZ_BP,
  parameter int unsigned VISIBLE_HEIGHT = DEF_VISIBLE_HEIGHT,
  parameter int unsigned VERT_FP        = DEF_VERT_FP,
  parameter int unsigned VSYNC_WIDTH    = DEF_VSYNC_WIDTH,
  parameter int unsigned VERT_BP        = DEF_VERT_BP,
  parameter int unsigned LOCK_FRAMES    = DEF_LOCK_FRAMES
) (
  input  logic              pixel_clk,
  input  logic              rst,
  vga_sync_detect_if.slave  vid
);

  localparam logic [15:0] H_TOTAL   = 16'(timing_total(VISIBLE_WIDTH, HORIZ_FP, HSYNC_WIDTH, HORIZ_BP));
  localparam logic [15:0] V_TOTAL   = 16'(timing_total(VISIBLE_HEIGHT, VERT_FP, VSYNC_WIDTH, VERT_BP));
  localparam logic [15:0] HS_START  = 16'(sync_start(VISIBLE_WIDTH, HORIZ_FP));
  localparam logic [15:0] VS_START  = 16'(sync_start(VISIBLE_HEIGHT, VERT_FP));
  localparam logic [15:0] VIS_W     = 16'(VISIBLE_WIDTH);
  localparam logic [15:0] VIS_H     = 16'(VISIBLE_HEIGHT);
  localparam logic [15:0] H_TIMEOUT = 16'(2 * timing_total(VISIBLE_WIDTH, HORIZ_FP, HSYNC_WIDTH, HORIZ_BP));
  localparam logic [15:0] V_TIMEOUT = 16'(2 * timing_total(VISIBLE_HEIGHT, VERT_FP, VSYNC_WIDTH, VERT_BP));
  localparam logic [15:0] LOCK_N    = 16'(LOCK_FRAMES);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic hs_fall, vs_fall;

  sync_fall_detect u_hs_fall (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .sync_n    (vid.vga_hsync),
    .fall      (hs_fall)
  );

  sync_fall_detect u_vs_fall (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .sync_n    (vid.vga_vsync),
    .fall      (vs_fall)
  );

  logic [15:0] col, row;
  logic [15:0] line_clks, frame_lines;
  logic [15:0] h_period_r, v_period_r;
  logic [15:0] good_cnt, good_nx, good_inc, h_meas;
  logic        h_seen, frame_bad, locked_r;
  logic        line_bad, frame_ok, timeout, enter_search;
  sync_state_e state, state_nx;

  assign h_meas   = sat_inc(line_clks);
  assign good_inc = good_cnt + 16'd1;
  assign line_bad = hs_fall && h_seen && (h_meas != H_TOTAL);
  // A line that ends on the vsync edge still belongs to the frame being closed.
  assign frame_ok = (frame_lines == V_TOTAL) && !frame_bad && !line_bad;
  assign timeout  = (line_clks >= H_TIMEOUT) || (frame_lines >= V_TIMEOUT);
  assign enter_search = (state_nx == SEARCH) && (state != SEARCH);

  always_comb begin
    state_nx = state;
    good_nx  = good_cnt;
    if (timeout) begin
      state_nx = SEARCH;
      good_nx  = '0;
    end else begin
      case (state)
        SEARCH: if (vs_fall) begin
          state_nx = ALIGN;
          good_nx  = '0;
        end
        ALIGN: if (vs_fall && frame_ok) begin
          good_nx = 16'd1;
          if (LOCK_N <= 16'd1) state_nx = LOCKED;
          else                 state_nx = TRACK;
        end
        TRACK: if (vs_fall) begin
          if (frame_ok) begin
            good_nx = good_inc;
            if (good_inc >= LOCK_N) state_nx = LOCKED;
          end else begin
            state_nx = ALIGN;
            good_nx  = '0;
          end
        end
        LOCKED: if (line_bad || (vs_fall && !frame_ok)) begin
          state_nx = SEARCH;
          good_nx  = '0;
        end
        default: state_nx = SEARCH;
      endcase
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      col         <= '0;
      row         <= '0;
      line_clks   <= '0;
      frame_lines <= '0;
      h_period_r  <= '0;
      v_period_r  <= '0;
      good_cnt    <= '0;
      h_seen      <= 1'b0;
      frame_bad   <= 1'b0;
      locked_r    <= 1'b0;
      state       <= SEARCH;
    end else begin
      // hs_fall lands one column past sync start because of the strobe's own edge.
      if (hs_fall)                  col <= HS_START + 16'd1;
      else if (col == H_TOTAL - 1)  col <= '0;
      else                          col <= col + 16'd1;

      if (vs_fall)
        row <= VS_START;
      else if (!hs_fall && col == H_TOTAL - 1)
        row <= (row == V_TOTAL - 1) ? 16'd0 : row + 16'd1;

      line_clks <= hs_fall ? 16'd0 : sat_inc(line_clks);

      if (vs_fall)      frame_lines <= hs_fall ? 16'd1 : 16'd0;
      else if (hs_fall) frame_lines <= sat_inc(frame_lines);

      if (hs_fall && h_seen)            h_period_r <= h_meas;
      if (vs_fall && state != SEARCH)   v_period_r <= frame_lines;

      if (enter_search) h_seen <= 1'b0;
      else if (hs_fall) h_seen <= 1'b1;

      if (vs_fall)       frame_bad <= 1'b0;
      else if (line_bad) frame_bad <= 1'b1;

      state    <= state_nx;
      good_cnt <= good_nx;
      locked_r <= (state_nx == LOCKED);
    end
  end

  assign vid.pixel_col   = col;
  assign vid.pixel_row   = row;
  assign vid.h_period    = h_period_r;
  assign vid.v_period    = v_period_r;
  assign vid.locked      = locked_r;
  assign vid.data_valid  = locked_r && (col < VIS_W) && (row < VIS_H);
  assign vid.frame_start = locked_r && (col == 16'd0) && (row == 16'd0);

endmodule

// File: tb/tb_vga_sync_detect.sv
// Directed bench for vga_sync_detect using a reduced 25x19 raster so that
// several lock/unlock cycles fit in a short run.
module tb_vga_sync_detect;

  localparam int HT = 25;   // 16 + 2 + 4 + 3
  localparam int VT = 19;   // 12 + 2 + 2 + 3

  logic pixel_clk = 1'b0;
  logic rst;
  always #5 pixel_clk = ~pixel_clk;

  vga_sync_detect_if vid ();

  vga_sync_detect #(
    .VISIBLE_WIDTH  (16),
    .HORIZ_FP       (2),
    .HSYNC_WIDTH    (4),
    .HORIZ_BP       (3),
    .VISIBLE_HEIGHT (12),
    .VERT_FP        (2),
    .VSYNC_WIDTH    (2),
    .VERT_BP        (3),
    .LOCK_FRAMES    (2)
  ) dut (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .vid       (vid)
  );

  typedef struct {
    int          line;
    int          col;
    bit          pos;
    logic        lk;
    logic [15:0] hp;
    logic [15:0] vp;
    logic [15:0] col_e;
    logic [15:0] row_e;
    logic        dv;
    logic        fs;
  } vec_t;

  vec_t vecs[13];

  int vectors, miscompares;
  int tx_line, tx_col, vtot, long_line, phase;
  bit hs_force, lock_seen;
  int dv_cnt, fs_cnt, track_err;

  function automatic int hlen(input int line);
    return (line == long_line) ? HT + 1 : HT;
  endfunction

  task automatic drive();
    int r;
    r = tx_line % vtot;
    vid.vga_hsync = hs_force || !(tx_col >= 18 && tx_col <= 21);
    vid.vga_vsync = !(r >= 14 && r <= 15);
  endtask

  task automatic step();
    int ec, er;
    @(posedge pixel_clk);
    #1;
    if (tx_col == hlen(tx_line) - 1) begin
      tx_col = 0;
      tx_line++;
    end else begin
      tx_col++;
    end
    drive();
    if (vid.locked) lock_seen = 1'b1;
    if (phase == 0 && tx_line >= 76 && tx_line <= 94) begin
      dv_cnt += int'(vid.data_valid);
      fs_cnt += int'(vid.frame_start);
    end
    if (phase == 0 && tx_line >= 57 && tx_line <= 94) begin
      ec = (tx_col + HT - 2) % HT;
      er = (tx_col >= 2) ? tx_line % VT : (tx_line + VT - 1) % VT;
      if (vid.pixel_col != 16'(ec) || vid.pixel_row != 16'(er) || !vid.locked)
        track_err++;
    end
  endtask

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic run_until(input int line, input int col);
    int n;
    n = 0;
    while (!(tx_line == line && tx_col == col) && n < 20000) begin
      step();
      n++;
    end
    if (n >= 20000) begin
      vectors++;
      miscompares++;
      $display("FAIL run_until(%0d,%0d): stopped at (%0d,%0d)", line, col, tx_line, tx_col);
    end
  endtask

  function automatic logic [79:0] all_outs();
    return {13'd0, vid.pixel_col, vid.pixel_row, vid.h_period, vid.v_period,
            vid.data_valid, vid.frame_start, vid.locked};
  endfunction

  task automatic do_reset();
    rst      = 1'b1;
    tx_line  = 0;
    tx_col   = 0;
    hs_force = 1'b0;
    drive();
    repeat (3) @(posedge pixel_clk);
    #3;
    check("reset_outputs", all_outs(), 80'd0);
    rst = 1'b0;
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    logic [79:0] got, exp;
    if (v.pos) begin
      got = {13'd0, vid.locked, vid.h_period, vid.v_period, vid.pixel_col, vid.pixel_row,
             vid.data_valid, vid.frame_start};
      exp = {13'd0, v.lk, v.hp, v.vp, v.col_e, v.row_e, v.dv, v.fs};
    end else begin
      got = {47'd0, vid.locked, vid.h_period, vid.v_period};
      exp = {47'd0, v.lk, v.hp, v.vp};
    end
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL vec%0d (%0d,%0d): lk=%b hp=%0d vp=%0d col=%0d row=%0d dv=%b fs=%b, expected lk=%b hp=%0d vp=%0d col=%0d row=%0d dv=%b fs=%b",
               idx, v.line, v.col, vid.locked, vid.h_period, vid.v_period, vid.pixel_col,
               vid.pixel_row, vid.data_valid, vid.frame_start, v.lk, v.hp, v.vp, v.col_e,
               v.row_e, v.dv, v.fs);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    vtot        = VT;
    long_line   = -1;
    phase       = 0;
    dv_cnt      = 0;
    fs_cnt      = 0;
    track_err   = 0;
    lock_seen   = 1'b0;

    //            line col pos lk  hp  vp col row dv fs
    vecs[0]  = '{ 1, 20, 0, 0,  0,  0,  0,  0, 0, 0};
    vecs[1]  = '{ 1, 21, 0, 0, 25,  0,  0,  0, 0, 0};
    vecs[2]  = '{33,  2, 0, 0, 25,  0,  0,  0, 0, 0};
    vecs[3]  = '{33,  3, 0, 0, 25, 19,  0,  0, 0, 0};
    vecs[4]  = '{52,  2, 0, 0, 25, 19,  0,  0, 0, 0};
    vecs[5]  = '{52,  3, 1, 1, 25, 19,  1, 14, 0, 0};
    vecs[6]  = '{57,  1, 1, 1, 25, 19, 24, 18, 0, 0};
    vecs[7]  = '{57,  2, 1, 1, 25, 19,  0,  0, 1, 1};
    vecs[8]  = '{57, 17, 1, 1, 25, 19, 15,  0, 1, 0};
    vecs[9]  = '{57, 18, 1, 1, 25, 19, 16,  0, 0, 0};
    vecs[10] = '{58,  2, 1, 1, 25, 19,  0,  1, 1, 0};
    vecs[11] = '{68,  5, 1, 1, 25, 19,  3, 11, 1, 0};
    vecs[12] = '{69,  5, 1, 1, 25, 19,  3, 12, 0, 0};

    do_reset();

    for (int i = 0; i < 13; i++) begin
      run_until(vecs[i].line, vecs[i].col);
      check_vec(i, vecs[i]);
    end

    run_until(95, 0);
    check("dv_per_frame", 80'(dv_cnt), 80'd192);
    check("fs_per_frame", 80'(fs_cnt), 80'd1);
    check("col_row_track", 80'(track_err), 80'd0);

    // One 26-clock line while locked, then relock three vsyncs later.
    long_line = 98;
    run_until(99, 20);
    check("long_line_before", {63'd0, vid.locked, vid.h_period}, {63'd0, 1'b1, 16'd25});
    run_until(99, 21);
    check("long_line_drop", {63'd0, vid.locked, vid.h_period}, {63'd0, 1'b0, 16'd26});
    run_until(147, 2);
    check("relock_pending", {63'd0, vid.locked, vid.h_period}, {63'd0, 1'b0, 16'd25});
    run_until(147, 3);
    check("relock", {63'd0, vid.locked, vid.v_period}, {63'd0, 1'b1, 16'd19});
    long_line = -1;

    // Hsync stuck high long enough to trip the line timeout.
    run_until(150, 0);
    hs_force = 1'b1;
    run_until(151, 10);
    check("hs_stuck_early", {79'd0, vid.locked}, {79'd0, 1'b1});
    run_until(152, 10);
    check("hs_timeout", {78'd0, vid.locked, vid.data_valid}, {78'd0, 2'b00});
    hs_force = 1'b0;

    // Asynchronous reset mid-frame while locked.
    run_until(210, 7);
    check("pre_reset_locked", {78'd0, vid.locked, vid.data_valid}, {78'd0, 2'b11});
    #2 rst = 1'b1;
    #1 check("async_reset", all_outs(), 80'd0);
    phase = 1;
    do_reset();
    run_until(52, 2);
    check("post_reset_pending", {79'd0, vid.locked}, {79'd0, 1'b0});
    run_until(52, 3);
    check("post_reset_lock", {79'd0, vid.locked}, {79'd0, 1'b1});

    // Frames one line short never lock.
    phase = 2;
    vtot  = VT - 1;
    do_reset();
    lock_seen = 1'b0;
    run_until(110, 0);
    check("short_v_period", 80'(vid.v_period), 80'd18);
    check("short_never_locks", {79'd0, lock_seen}, 80'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
